// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder with req/ack handshake, wait states and fault flagging
// Ports:
//   clk_i    rising-edge clock
//   rst_n_i  asynchronous active-low reset
//   req_i    access request, fields valid while high
//   we_i     1=store, 0=load
//   addr_i   byte address (word aligned)
//   wdata_i  store data
//   ack_o    one-cycle response strobe
//   rdata_o  load data, valid with ack_o on loads, held until next response
//   err_o    access fault, valid with ack_o, held until next response
//   stall_o  pipeline stall request (req_i & ~ack_o)
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        stall_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be in 1..15");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dmem_responder: DEPTH must be a power of 2 and >= 4");
  end
  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_mem [DEPTH];
  logic          w_accept;
  logic          w_fire;
  logic          w_fault;
  logic [AW-1:0] w_idx;
  // RESP accepts a new request exactly like IDLE, giving back-to-back service
  assign w_accept = req_i && (r_state == S_IDLE || r_state == S_RESP);
  assign w_fire   = (r_state == S_BUSY) && (r_cnt == 4'd0);
  assign w_idx    = r_addr[AW+1:2];
  // DEPTH is a power of 2, so "word index >= DEPTH" is any set bit above the index field
  assign w_fault  = (r_addr[1:0] != 2'b00) || (|r_addr[31:AW+2]);
  assign stall_o  = req_i & ~ack_o;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= 32'd0;
    end else begin
      ack_o <= w_fire;
      if (w_accept) begin
        r_state <= S_BUSY;
        r_cnt   <= 4'(LATENCY - 1);
        r_we    <= we_i;
        r_addr  <= addr_i;
        r_wdata <= wdata_i;
      end else if (r_state == S_BUSY) begin
        r_cnt <= w_fire ? r_cnt : r_cnt - 4'd1;
        if (w_fire) begin
          r_state <= S_RESP;
          err_o   <= w_fault;
          if (w_fault) rdata_o <= 32'd0;
          else if (!r_we) rdata_o <= r_mem[w_idx];
        end
      end else if (r_state == S_RESP) begin
        r_state <= S_IDLE;
      end
    end
  end
  // RAM is not reset; a reset drops the FSM out of BUSY so a pending store never fires
  always_ff @(posedge clk_i) begin
    if (w_fire && r_we && !w_fault) r_mem[w_idx] <= r_wdata;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder at LATENCY 3, 1 and 15
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req [3];
  logic        we [3];
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic        ack [3];
  logic [31:0] rdata [3];
  logic        err [3];
  logic        stall [3];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  dmem_responder #(.DEPTH(256), .LATENCY(3)) u_l3 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]), .wdata_i(wdata[0]),
    .ack_o(ack[0]), .rdata_o(rdata[0]), .err_o(err[0]), .stall_o(stall[0]));
  dmem_responder #(.DEPTH(256), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]), .wdata_i(wdata[1]),
    .ack_o(ack[1]), .rdata_o(rdata[1]), .err_o(err[1]), .stall_o(stall[1]));
  dmem_responder #(.DEPTH(256), .LATENCY(15)) u_l15 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req[2]), .we_i(we[2]), .addr_i(addr[2]), .wdata_i(wdata[2]),
    .ack_o(ack[2]), .rdata_o(rdata[2]), .err_o(err[2]), .stall_o(stall[2]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // One access on unit u: drive at negedge, accept on next edge, expect ack exactly lat edges later.
  // b2b: called during the previous ack cycle (stall low then); keep: hold req across the ack.
  task automatic acc(input int u, input int lat, input logic b2b, input logic keep, input logic w,
                     input logic [31:0] a, input logic [31:0] d, input logic [31:0] er,
                     input logic ee, input string tag);
    if (!b2b) @(negedge clk);
    req[u] = 1'b1; we[u] = w; addr[u] = a; wdata[u] = d;
    #1 chk({tag, "_stall_pre"}, stall[u], b2b ? 1'b0 : 1'b1);
    @(posedge clk);
    for (int k = 1; k <= lat; k++) begin
      #1;
      if (k == 1) begin
        addr[u] = a ^ 32'h4; wdata[u] = ~d; we[u] = ~w;
      end
      @(posedge clk);
      #1 chk({tag, "_ack"}, ack[u], k == lat);
      if (k == 1 && lat > 1) chk({tag, "_stall_busy"}, stall[u], 1'b1);
    end
    chk({tag, "_err"}, err[u], ee);
    chk({tag, "_rdata"}, rdata[u], er);
    chk({tag, "_stall_ack"}, stall[u], 1'b0);
    if (keep) begin
      #1;
    end else begin
      req[u] = 1'b0;
      @(posedge clk);
      #1 chk({tag, "_ack_drop"}, ack[u], 1'b0);
      chk({tag, "_hold"}, rdata[u], er);
    end
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 32'd0;
    end
    rst_n = 1'b0;
    #7;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ack", ack[i], 1'b0);
      chk("rst_err", err[i], 1'b0);
      chk("rst_rdata", rdata[i], 32'd0);
      chk("rst_stall", stall[i], 1'b0);
    end
    @(negedge clk) rst_n = 1'b1;
    acc(0, 3, 1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "st10");
    acc(0, 3, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "ld10");
    acc(0, 3, 1'b0, 1'b0, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, "ld13_mis");
    acc(0, 3, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0BADC0DE, 32'h0, 1'b0, "st0");
    acc(0, 3, 1'b0, 1'b0, 1'b1, 32'h400, 32'h11111111, 32'h0, 1'b1, "st_oor");
    acc(0, 3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0BADC0DE, 1'b0, "ld0");
    acc(0, 3, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "ld10_again");
    acc(0, 3, 1'b0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0, "st20");
    acc(0, 3, 1'b0, 1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0, "b2b_st");
    acc(0, 3, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 32'hA5A5A5A5, 1'b0, "b2b_ld");
    @(negedge clk);
    chk("idle_stall", stall[0], 1'b0);
    acc(0, 3, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "ld10_pre_rst");
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h12345678;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_ack", ack[0], 1'b0);
    chk("midrst_err", err[0], 1'b0);
    chk("midrst_rdata", rdata[0], 32'd0);
    req[0] = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("midrst_no_ack", ack[0], 1'b0);
    acc(0, 3, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, "ld20_after_rst");
    acc(1, 1, 1'b0, 1'b0, 1'b1, 32'h8, 32'h01010101, 32'h0, 1'b0, "l1_st");
    acc(1, 1, 1'b0, 1'b1, 1'b1, 32'hC, 32'h02020202, 32'h0, 1'b0, "l1_b2b_st");
    acc(1, 1, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h01010101, 1'b0, "l1_ld");
    repeat (5) @(posedge clk);
    #1 chk("l1_hold_idle", rdata[1], 32'h01010101);
    acc(2, 15, 1'b0, 1'b0, 1'b1, 32'h3FC, 32'hF0F0F0F0, 32'h0, 1'b0, "l15_st_last");
    acc(2, 15, 1'b0, 1'b0, 1'b0, 32'h3FC, 32'h0, 32'hF0F0F0F0, 1'b0, "l15_ld_last");
    repeat (5) @(posedge clk);
    #1 chk("l15_hold_idle", rdata[2], 32'hF0F0F0F0);
    chk("l15_err_hold", err[2], 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
